// File: rtl/fsk_bit_slicer.sv
// Bit-window timing and tone decision stage behind frequency_analyzer.
// Runs one clear/accumulate/settle/decide window per bit and streams decided bits out.
module fsk_bit_slicer #(
    parameter int unsigned CLOCK_FREQUENCY      = 50000000,
    parameter int unsigned BIT_RATE             = 1000,
    parameter int unsigned MIN_RATIO_PERCENT    = 60,
    parameter int unsigned MIN_ACTIVITY_PERCENT = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] f0_value,
    input  logic [31:0] f1_value,
    output logic        analyzer_enable,
    output logic        analyzer_clear_n,
    output logic        bit_data,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        carrier_detect,
    output logic [15:0] error_count,
    output logic        overflow
);

    localparam int unsigned BIT_TICKS = CLOCK_FREQUENCY / BIT_RATE;
    localparam int unsigned ACC_TICKS = BIT_TICKS - 3;
    localparam int unsigned CNT_W     = $clog2(BIT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUMULATE,
        S_SETTLE,
        S_DECIDE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               analyzer_enable_q, analyzer_enable_d;
    logic               analyzer_clear_n_q, analyzer_clear_n_d;
    logic               bit_data_q, bit_data_d;
    logic               bit_valid_q, bit_valid_d;
    logic               carrier_detect_q, carrier_detect_d;
    logic [15:0]        error_count_q, error_count_d;
    logic               overflow_q, overflow_d;

    logic [63:0] total, total_pct, f0_pct, f1_pct, ratio_min, activity_min;
    logic        carrier, is_one, is_zero;
    logic        new_valid, new_bit;

    always_comb begin
        total        = {32'd0, f0_value} + {32'd0, f1_value};
        total_pct    = total * 64'd100;
        f0_pct       = {32'd0, f0_value} * 64'd100;
        f1_pct       = {32'd0, f1_value} * 64'd100;
        ratio_min    = total * 64'(MIN_RATIO_PERCENT);
        activity_min = 64'(ACC_TICKS) * 64'(MIN_ACTIVITY_PERCENT);
        carrier      = (total_pct >= activity_min);
        is_one       = (f1_pct >= ratio_min);
        is_zero      = (f0_pct >= ratio_min);
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        carrier_detect_d = carrier_detect_q;
        error_count_d    = error_count_q;
        bit_data_d       = bit_data_q;
        bit_valid_d      = bit_valid_q;
        overflow_d       = overflow_q;
        new_valid        = 1'b0;
        new_bit          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_ACCUMULATE;
                cnt_d   = '0;
            end
            S_ACCUMULATE: begin
                if (cnt_q == CNT_W'(ACC_TICKS - 1)) state_d = S_SETTLE;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            S_SETTLE: begin
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                state_d          = S_CLEAR;
                carrier_detect_d = carrier;
                if (carrier) begin
                    if (is_one) begin
                        new_valid = 1'b1;
                        new_bit   = 1'b1;
                    end else if (is_zero) begin
                        new_valid = 1'b1;
                    end else if (error_count_q != '1) begin
                        error_count_d = error_count_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // DECIDE still evaluates its completed window even when enable drops there
        if (!enable && state_q != S_IDLE) state_d = S_IDLE;

        if (new_valid) begin
            if (!bit_valid_q || bit_ready) begin
                bit_data_d  = new_bit;
                bit_valid_d = 1'b1;
            end else begin
                overflow_d  = 1'b1;
            end
        end else if (bit_valid_q && bit_ready) begin
            bit_valid_d = 1'b0;
        end

        analyzer_enable_d  = (state_d == S_ACCUMULATE);
        analyzer_clear_n_d = (state_d == S_ACCUMULATE) || (state_d == S_SETTLE) ||
                             (state_d == S_DECIDE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            analyzer_enable_q  <= 1'b0;
            analyzer_clear_n_q <= 1'b0;
            bit_data_q         <= 1'b0;
            bit_valid_q        <= 1'b0;
            carrier_detect_q   <= 1'b0;
            error_count_q      <= '0;
            overflow_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            analyzer_enable_q  <= analyzer_enable_d;
            analyzer_clear_n_q <= analyzer_clear_n_d;
            bit_data_q         <= bit_data_d;
            bit_valid_q        <= bit_valid_d;
            carrier_detect_q   <= carrier_detect_d;
            error_count_q      <= error_count_d;
            overflow_q         <= overflow_d;
        end
    end

    assign analyzer_enable  = analyzer_enable_q;
    assign analyzer_clear_n = analyzer_clear_n_q;
    assign bit_data         = bit_data_q;
    assign bit_valid        = bit_valid_q;
    assign carrier_detect   = carrier_detect_q;
    assign error_count      = error_count_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_fsk_bit_slicer.sv
// Scoreboard bench for fsk_bit_slicer with 1000-cycle bit windows.
module tb_fsk_bit_slicer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] f0_value;
    logic [31:0] f1_value;
    logic        analyzer_enable;
    logic        analyzer_clear_n;
    logic        bit_data;
    logic        bit_valid;
    logic        bit_ready;
    logic        carrier_detect;
    logic [15:0] error_count;
    logic        overflow;

    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        exp_q[$];
    int unsigned hs_q[$];

    fsk_bit_slicer #(
        .CLOCK_FREQUENCY(1000000),
        .BIT_RATE(1000),
        .MIN_RATIO_PERCENT(60),
        .MIN_ACTIVITY_PERCENT(50)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .f0_value(f0_value),
        .f1_value(f1_value),
        .analyzer_enable(analyzer_enable),
        .analyzer_clear_n(analyzer_clear_n),
        .bit_data(bit_data),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .carrier_detect(carrier_detect),
        .error_count(error_count),
        .overflow(overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Drive point: 1 time unit after the edge that starts cycle t.
    task automatic at_cyc(input int unsigned t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aen"}, analyzer_enable, 0);
        check({tag, "_clrn"}, analyzer_clear_n, 0);
        check({tag, "_data"}, bit_data, 0);
        check({tag, "_valid"}, bit_valid, 0);
        check({tag, "_carrier"}, carrier_detect, 0);
        check({tag, "_errcnt"}, error_count, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    // Scoreboard: every accepted bit is compared against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && bit_valid && bit_ready) begin
            hs_q.push_back(cyc);
            check("bit_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("bit_data", bit_data, exp_q.pop_front());
        end
    end

    task automatic check_handshakes(input string tag, input int unsigned start, input int unsigned n);
        check({tag, "_count"}, hs_q.size(), n);
        for (int i = 0; i < hs_q.size() && i < int'(n); i++)
            check({tag, "_spacing"}, hs_q[i], start + 1000 * (i + 1));
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        hs_q.delete();
    endtask

    // Runs n full windows from IDLE with fixed tones, then aborts the next window.
    task automatic run_phase(input string tag, input logic [31:0] f0, input logic [31:0] f1,
                             input int unsigned n, input int exp_bit);
        int unsigned start;
        hs_q.delete();
        f0_value = f0;
        f1_value = f1;
        if (exp_bit >= 0)
            for (int i = 0; i < int'(n); i++) exp_q.push_back(exp_bit[0]);
        enable = 1'b1;
        start  = cyc + 1;
        at_cyc(start + 1000 * n + 2);
        enable = 1'b0;
        at_cyc(start + 1000 * n + 5);
        @(negedge clock);
        check_handshakes(tag, start, (exp_bit >= 0) ? n : 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned start;
        reset     = 1'b1;
        enable    = 1'b0;
        bit_ready = 1'b1;
        f0_value  = '0;
        f1_value  = '0;
        at_cyc(3);
        @(negedge clock);
        check_reset_outputs("reset");
        at_cyc(4);
        reset = 1'b0;
        at_cyc(6);

        run_phase("t1_one", 32'd0, 32'd900, 3, 1);
        check("t1_carrier", carrier_detect, 1);
        check("t1_errcnt", error_count, 0);

        run_phase("t2_zero", 32'd800, 32'd100, 2, 0);
        check("t2_carrier", carrier_detect, 1);
        check("t2_errcnt", error_count, 0);

        run_phase("t3_ambig", 32'd450, 32'd450, 3, -1);
        check("t3_carrier", carrier_detect, 1);
        check("t3_errcnt", error_count, 3);

        run_phase("t4_nocarrier", 32'd100, 32'd200, 2, -1);
        check("t4_carrier", carrier_detect, 0);
        check("t4_errcnt", error_count, 3);

        run_phase("b_act499", 32'd0, 32'd499, 1, 1);
        check("b_act499_carrier", carrier_detect, 1);
        run_phase("b_act498", 32'd0, 32'd498, 1, -1);
        check("b_act498_carrier", carrier_detect, 0);
        run_phase("b_ratio60", 32'd400, 32'd600, 1, 1);
        check("b_ratio60_errcnt", error_count, 3);
        run_phase("b_ratio59", 32'd401, 32'd599, 1, -1);
        check("b_ratio59_errcnt", error_count, 4);
        check("b_ratio59_carrier", carrier_detect, 1);

        // Back-pressure: first bit held, later bits dropped
        hs_q.delete();
        bit_ready = 1'b0;
        f0_value  = 32'd0;
        f1_value  = 32'd900;
        exp_q.push_back(1'b1);
        enable = 1'b1;
        start  = cyc + 1;
        at_cyc(start + 1000);
        @(negedge clock);
        check("t5_valid1", bit_valid, 1);
        check("t5_ovf1", overflow, 0);
        at_cyc(start + 1001);
        f0_value = 32'd800;
        f1_value = 32'd100;
        at_cyc(start + 2000);
        @(negedge clock);
        check("t5_ovf2", overflow, 1);
        check("t5_held2", bit_data, 1);
        at_cyc(start + 3000);
        @(negedge clock);
        check("t5_held3", bit_data, 1);
        check("t5_valid3", bit_valid, 1);
        at_cyc(start + 3001);
        bit_ready = 1'b1;
        at_cyc(start + 3003);
        @(negedge clock);
        check("t5_drained", bit_valid, 0);
        check("t5_ovf_sticky", overflow, 1);
        enable = 1'b0;
        at_cyc(start + 3006);
        check("t5_count", hs_q.size(), 1);
        if (hs_q.size() != 0) check("t5_hs_cycle", hs_q[0], start + 3001);
        check("t5_sb_empty", exp_q.size(), 0);
        hs_q.delete();

        // Abort mid-accumulate, then restart
        f0_value = 32'd0;
        f1_value = 32'd900;
        enable   = 1'b1;
        start    = cyc + 1;
        at_cyc(start + 500);
        @(negedge clock);
        check("t6_aen_running", analyzer_enable, 1);
        check("t6_clrn_running", analyzer_clear_n, 1);
        at_cyc(start + 501);
        enable = 1'b0;
        at_cyc(start + 502);
        @(negedge clock);
        check("t6_aen_abort", analyzer_enable, 0);
        check("t6_clrn_abort", analyzer_clear_n, 0);
        at_cyc(start + 1200);
        check("t6_no_bit", hs_q.size(), 0);
        exp_q.push_back(1'b1);
        enable = 1'b1;
        start  = cyc + 1;
        at_cyc(start);
        @(negedge clock);
        check("t6_clear_cycle", analyzer_clear_n, 0);
        at_cyc(start + 1002);
        enable = 1'b0;
        at_cyc(start + 1005);
        check_handshakes("t6_restart", start, 1);

        // Reset mid-accumulate with a bit held
        bit_ready = 1'b0;
        enable    = 1'b1;
        start     = cyc + 1;
        at_cyc(start + 1000);
        @(negedge clock);
        check("t7_valid_before", bit_valid, 1);
        at_cyc(start + 1500);
        reset = 1'b1;
        at_cyc(start + 1501);
        @(negedge clock);
        check_reset_outputs("t7");
        enable = 1'b0;
        at_cyc(start + 1503);
        reset = 1'b0;
        at_cyc(start + 1506);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
